// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, fetch window size and the
// memory responder state type.
package cpu_pkg;

    localparam logic [15:0] RESET_VECTOR = 16'h8000;
    localparam int          FETCH_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } fetch_mem_state_t;

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port byte RAM, 2^ADDR_W deep, registered read (latency 1).
// Contents are deliberately not reset.
module mem_byte_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Write when enabled; always read the addressed byte (old data on a same-cycle write)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fetch_mem_responder.sv
// Program memory responder: serves 4-byte fetch windows and single-byte
// writes over a valid/ready request/response handshake.
// Optional build macro FETCH_MEM_WRPROT_EN: drop writes to the upper half
// of the address space and flag them with rsp_err.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | issuing window addresses a+0..a+3, assembling bytes (counter 0..4)
// WR    | single cycle, commit (or drop) the byte write
// RESP  | holding the response until rsp_ready
module fetch_mem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    fetch_mem_state_t  state, state_nxt;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_rdata;
    logic              wr_prot;

    // The counter doubles as the byte offset; it is 0 in WR so the same adder serves both
    assign ram_addr  = addr_q + {{(ADDR_W-3){1'b0}}, cnt};
    // A reset edge must not let an uncommitted write reach the array
    assign ram_we    = (state == WR) && !wr_prot && !rst;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = data_q;

`ifdef FETCH_MEM_WRPROT_EN
    logic err_q;

    assign wr_prot = addr_q[ADDR_W-1];
    assign rsp_err = err_q;

    // Error flag: cleared on each acceptance, set when a write is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            err_q <= 1'b0;
        end else if (state == WR) begin
            err_q <= wr_prot;
        end
    end
`else
    assign wr_prot = 1'b0;
    assign rsp_err = 1'b0;
`endif

    mem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_we ? WR : RD;
            RD:   if (cnt == 3'(FETCH_BYTES)) state_nxt = RESP;
            WR:   state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request latch, counter and window assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            data_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 3'd0;
                        if (req_we) begin
                            data_q <= 32'd0;
                        end
                    end
                end
                RD: begin
                    cnt <= cnt + 3'd1;
                    // Read data lags the issued address by one cycle
                    if (cnt != 3'd0) begin
                        data_q[{cnt - 3'd1, 3'b000} +: 8] <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
